// File: rtl/cct_conditioner.sv
// Ambient-light CCT conditioner: polls the sensor, clamps and EMA-filters the
// returned colour temperature, and forwards only settled changes downstream.
module cct_conditioner #(
   parameter int unsigned CLK_FREQ       = 50_000_000,
   parameter int unsigned POLL_CYCLES    = 5_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [15:0] CCT_MIN        = 16'd3000,
   parameter logic [15:0] CCT_MAX        = 16'd8000,
   parameter logic [15:0] CCT_DEFAULT    = 16'd6500,
   parameter int unsigned ALPHA_SHIFT    = 2,
   parameter logic [15:0] HYST           = 16'd100,
   parameter int unsigned SETTLE_CNT     = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   output logic        o_read_req,
   input  logic        i_als_busy,
   input  logic [15:0] i_cct_in,
   input  logic        i_cct_in_valid,
   output logic [15:0] o_cct_out,
   output logic        o_cct_out_valid,
   input  logic        i_cct_out_ready,
   output logic        o_timeout_pulse
);

   // Counters are sized for the longer interval, never below one second of clocks.
   localparam int unsigned CNT_SPAN = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W    = $clog2(((CNT_SPAN > CLK_FREQ) ? CNT_SPAN : CLK_FREQ) + 1);
   localparam logic [CNT_W-1:0] POLL_LAST    = CNT_W'(POLL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam int unsigned SET_W = $clog2(SETTLE_CNT + 1);
   localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CNT);
   localparam logic [SET_W-1:0] SET_ONE    = SET_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT_DATA = 3'd2,
      S_FILTER    = 3'd3,
      S_COMPARE   = 3'd4,
      S_OUTPUT    = 3'd5
   } state_t;

   function automatic logic [15:0] f_clamp(input logic [15:0] v);
      if (v < CCT_MIN) begin
         return CCT_MIN;
      end else if (v > CCT_MAX) begin
         return CCT_MAX;
      end else begin
         return v;
      end
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_poll_cnt;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [15:0]        r_sample;
   logic [15:0]        r_filt;
   logic [15:0]        r_cct_out;
   logic               r_out_valid;
   logic               r_read_req;
   logic               r_timeout;
   logic               r_primed;
   logic               r_first;
   logic [SET_W-1:0]   r_settle;

   logic               w_fire_req;
   logic               w_take;
   logic               w_timeout;
   logic               w_commit;
   logic               w_release;
   logic signed [16:0] w_diff;
   logic signed [16:0] w_step;
   logic [15:0]        w_filt_ema;
   logic [15:0]        w_dist;
   logic               w_out_band;
   logic [SET_W-1:0]   w_settle_nxt;
   logic               w_commit_ok;

   // Arithmetic shift of the signed error gives floor rounding of the EMA step.
   assign w_diff       = $signed({1'b0, r_sample}) - $signed({1'b0, r_filt});
   assign w_step       = w_diff >>> ALPHA_SHIFT;
   assign w_filt_ema   = r_filt + 16'(w_step);
   assign w_dist       = (r_filt >= r_cct_out) ? (r_filt - r_cct_out) : (r_cct_out - r_filt);
   assign w_out_band   = (w_dist >= HYST);
   assign w_settle_nxt = w_out_band ? ((r_settle == SETTLE_MAX) ? SETTLE_MAX : (r_settle + SET_ONE))
                                    : {SET_W{1'b0}};
   assign w_commit_ok  = r_first | (w_settle_nxt == SETTLE_MAX);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and one-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_fire_req  = 1'b0;
      w_take      = 1'b0;
      w_timeout   = 1'b0;
      w_commit    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_poll_cnt == POLL_LAST) begin
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ: begin
            if (i_enable && !i_als_busy) begin
               w_fire_req  = 1'b1;
               w_state_nxt = S_WAIT_DATA;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_WAIT_DATA: begin
            if (i_cct_in_valid) begin
               w_take      = 1'b1;
               w_state_nxt = S_FILTER;
            end else if (r_wait_cnt == TIMEOUT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT_DATA;
            end
         end
         S_FILTER: begin
            w_state_nxt = S_COMPARE;
         end
         S_COMPARE: begin
            if (w_commit_ok) begin
               w_commit    = 1'b1;
               w_state_nxt = S_OUTPUT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_OUTPUT: begin
            if (i_cct_out_ready) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_OUTPUT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Poll and wait timers restart from zero on every entry to their state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_poll_cnt <= {CNT_W{1'b0}};
         r_wait_cnt <= {CNT_W{1'b0}};
      end else begin
         r_poll_cnt <= (r_state == S_IDLE)      ? (r_poll_cnt + CNT_ONE) : {CNT_W{1'b0}};
         r_wait_cnt <= (r_state == S_WAIT_DATA) ? (r_wait_cnt + CNT_ONE) : {CNT_W{1'b0}};
      end
   end

   // Sample capture, filter, settle tracking and the registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sample    <= CCT_DEFAULT;
         r_filt      <= CCT_DEFAULT;
         r_cct_out   <= CCT_DEFAULT;
         r_out_valid <= 1'b0;
         r_read_req  <= 1'b0;
         r_timeout   <= 1'b0;
         r_primed    <= 1'b0;
         r_first     <= 1'b0;
         r_settle    <= {SET_W{1'b0}};
      end else begin
         r_read_req <= w_fire_req;
         r_timeout  <= w_timeout;
         if (w_take) begin
            r_sample <= f_clamp(i_cct_in);
         end
         if (r_state == S_FILTER) begin
            if (!r_primed) begin
               r_filt   <= r_sample;
               r_primed <= 1'b1;
               r_first  <= 1'b1;
            end else begin
               r_filt   <= w_filt_ema;
            end
         end
         if (r_state == S_COMPARE) begin
            r_first <= 1'b0;
            if (w_commit) begin
               r_cct_out   <= r_filt;
               r_out_valid <= 1'b1;
               r_settle    <= {SET_W{1'b0}};
            end else begin
               r_settle    <= w_settle_nxt;
            end
         end
         if (w_release) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_read_req      = r_read_req;
   assign o_timeout_pulse = r_timeout;
   assign o_cct_out       = r_cct_out;
   assign o_cct_out_valid = r_out_valid;

endmodule

// File: tb/tb_cct_conditioner.sv
// Randomized bench for cct_conditioner: acts as the sensor interface and the
// downstream consumer, and predicts every commit from a floor-division EMA model.
module tb_cct_conditioner;

   localparam int POLL   = 20;
   localparam int TMO    = 15;
   localparam int CMIN   = 3000;
   localparam int CMAX   = 8000;
   localparam int CDEF   = 6500;
   localparam int ASH    = 2;
   localparam int HYST   = 100;
   localparam int SETTLE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        busy = 1'b0;
   logic [15:0] cct_in = 16'd0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        read_req;
   logic [15:0] cct_out;
   logic        out_valid;
   logic        timeout;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int m_filt, m_out, m_settle;
   bit m_primed;

   cct_conditioner #(
      .POLL_CYCLES    (POLL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_enable        (enable),
      .o_read_req      (read_req),
      .i_als_busy      (busy),
      .i_cct_in        (cct_in),
      .i_cct_in_valid  (in_valid),
      .o_cct_out       (cct_out),
      .o_cct_out_valid (out_valid),
      .i_cct_out_ready (out_ready),
      .o_timeout_pulse (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) check_eq("req_timeout_overlap", {31'd0, read_req & timeout}, 32'd0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int floor_div(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   task automatic model_sample(input int raw, output bit commit);
      int  s;
      bit  first;
      s = (raw < CMIN) ? CMIN : ((raw > CMAX) ? CMAX : raw);
      first = !m_primed;
      if (first) begin
         m_filt   = s;
         m_primed = 1'b1;
      end else begin
         m_filt = m_filt + floor_div(s - m_filt, 1 << ASH);
      end
      if ((m_filt - m_out >= HYST) || (m_out - m_filt >= HYST))
         m_settle = (m_settle < SETTLE) ? m_settle + 1 : SETTLE;
      else
         m_settle = 0;
      commit = first || (m_settle == SETTLE);
      if (commit) begin
         m_out    = m_filt;
         m_settle = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_read_req", {31'd0, read_req}, 32'd0);
      check_eq("rst_cct_out", {16'd0, cct_out}, CDEF);
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
      rst = 1'b0;
      m_filt = CDEF; m_out = CDEF; m_settle = 0; m_primed = 1'b0;
   endtask

   // Count cycles until read_req; optionally throw stray strobes before WAIT_DATA.
   task automatic wait_req(input int exp_gap, input bit spur);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 3 * POLL + TMO) begin
         tick();
         n++;
         seen = read_req;
         if (!seen && spur) begin
            in_valid = 1'($urandom_range(0, 1));
            cct_in   = 16'($urandom);
         end else begin
            in_valid = 1'b0;
         end
      end
      check_eq("req_gap", n, exp_gap);
      check_eq("valid_before_req", {31'd0, out_valid}, 32'd0);
   endtask

   // hold < 0 leaves the DUT in OUTPUT with valid high.
   task automatic finish_read(input bit give, input int raw, input int dly, input int hold);
      int n;
      bit commit;
      if (!give) begin
         n = 0;
         while (!timeout && n < TMO + 5) begin
            tick();
            n++;
         end
         check_eq("timeout_gap", n, TMO);
         check_eq("timeout_keeps_out", {16'd0, cct_out}, m_out);
         return;
      end
      for (int i = 0; i < dly; i++) begin
         tick();
         check_eq("req_one_cycle", {31'd0, read_req}, 32'd0);
      end
      if (hold == 0) out_ready = 1'b1;
      cct_in = 16'(raw); in_valid = 1'b1;
      tick();
      in_valid = 1'b0; cct_in = 16'($urandom);
      model_sample(raw, commit);
      tick();
      check_eq("valid_early", {31'd0, out_valid}, 32'd0);
      tick();
      check_eq("commit", {31'd0, out_valid}, {31'd0, commit});
      check_eq("cct_out", {16'd0, cct_out}, m_out);
      if (commit) begin
         if (hold < 0) return;
         for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_out", {16'd0, cct_out}, m_out);
         end
         out_ready = 1'b1;
         tick();
         check_eq("valid_drop", {31'd0, out_valid}, 32'd0);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      int hits;
      int kind, raw;
      do_reset();

      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 7000, 0, 10);
      check_eq("first_sample", {16'd0, cct_out}, 7000);

      do_reset();
      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 9000, 2, 1);
      check_eq("clamp_hi", {16'd0, cct_out}, 8000);
      do_reset();
      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 1000, 1, 1);
      check_eq("clamp_lo", {16'd0, cct_out}, 3000);

      do_reset();
      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 6000, 1, 0);
      for (int k = 0; k < 3; k++) begin
         wait_req(POLL + 1, 1'b1);
         finish_read(1'b1, 7000, 3, 2);
      end
      check_eq("ema_commit", {16'd0, cct_out}, 6577);

      do_reset();
      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 6000, 0, 1);
      for (int k = 0; k < 10; k++) begin
         wait_req(POLL + 1, 1'b0);
         finish_read(1'b1, 6080, 2, 1);
      end
      check_eq("hyst_hold", {16'd0, cct_out}, 6000);

      wait_req(POLL + 1, 1'b0);
      finish_read(1'b0, 0, 0, 0);
      check_eq("timeout_out", {16'd0, cct_out}, 6000);

      busy = 1'b1; hits = 0;
      for (int i = 0; i < POLL + 10; i++) begin
         tick();
         hits += int'(read_req);
      end
      check_eq("busy_blocks", hits, 0);
      busy = 1'b0;
      wait_req(1, 1'b0);
      finish_read(1'b1, 6080, 0, 1);

      enable = 1'b0; hits = 0;
      for (int i = 0; i < POLL + 10; i++) begin
         tick();
         hits += int'(read_req);
      end
      check_eq("enable_blocks", hits, 0);
      enable = 1'b1;
      wait_req(1, 1'b0);
      finish_read(1'b1, 6080, 1, 1);

      for (int t = 0; t < 50; t++) begin
         wait_req(POLL + 1, 1'($urandom_range(0, 1)));
         kind = int'($urandom_range(0, 99));
         if (kind < 12) begin
            finish_read(1'b0, 0, 0, 0);
         end else begin
            if (kind < 45)      raw = m_out + int'($urandom_range(0, 300)) - 150;
            else if (kind < 70) raw = m_out + int'($urandom_range(0, 800)) - 400;
            else if (kind < 92) raw = int'($urandom_range(0, 12000));
            else                raw = int'($urandom_range(0, 65535));
            if (raw < 0) raw = 0;
            finish_read(1'b1, raw, int'($urandom_range(0, TMO - 2)), int'($urandom_range(0, 4)));
         end
      end

      do_reset();
      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 4000, 0, -1);
      rst = 1'b1;
      tick();
      check_eq("rst_in_output_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_in_output_cct", {16'd0, cct_out}, CDEF);
      rst = 1'b0;
      m_filt = CDEF; m_out = CDEF; m_settle = 0; m_primed = 1'b0;
      wait_req(POLL + 1, 1'b0);
      finish_read(1'b1, 5000, 0, 1);
      check_eq("reprime", {16'd0, cct_out}, 5000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cct_conditioner.md
# cct_conditioner

Sits directly downstream of the I2C ambient-light-sensor interface. Schedules periodic sensor reads, then clamps and smooths the raw CCT samples it returns. Applies hysteresis and settling so that only stable illuminant changes are forwarded to the chromatic-adaptation matrix stage, over a valid/ready handshake.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz (informational).
- POLL_CYCLES, 5_000_000: cycles from IDLE entry to the next read request (100 ms at 50 MHz).
- TIMEOUT_CYCLES, 1_000_000: maximum wait in WAIT_DATA for a sample.
- CCT_MIN, 3000: lower clamp in K.
- CCT_MAX, 8000: upper clamp in K.
- CCT_DEFAULT, 6500: reset value of the committed CCT.
- ALPHA_SHIFT, 2: EMA weight is 2^-ALPHA_SHIFT.
- HYST, 100: commit threshold in K.
- SETTLE_CNT, 3: consecutive out-of-band filtered samples required to commit.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new read requests.
- read_req  out  1  one-cycle pulse to the sensor interface.
- als_busy  in  1  sensor interface busy.
- cct_in  in  16  raw CCT sample in K.
- cct_in_valid  in  1  one-cycle sample strobe.
- cct_out  out  16  committed CCT in K.
- cct_out_valid  out  1  committed value is offered downstream.
- cct_out_ready  in  1  downstream accepts the offered value.
- timeout_pulse  out  1  one-cycle flag when a read times out.

## Operation
- FSM states: IDLE, REQ, WAIT_DATA, FILTER, COMPARE, OUTPUT.
- IDLE: the poll timer counts from 0 on entry. When the timer reaches POLL_CYCLES-1, go to REQ.
- REQ: waits while enable=0 or als_busy=1. Otherwise drive read_req=1 for exactly one cycle, clear the wait counter, and go to WAIT_DATA.
- WAIT_DATA:
  - On cct_in_valid: register the clamped sample, min(max(cct_in, CCT_MIN), CCT_MAX), and go to FILTER.
  - When the wait counter reaches TIMEOUT_CYCLES-1 without a sample: pulse timeout_pulse and return to IDLE. Filter state is unchanged.
- cct_in_valid is ignored in every state except WAIT_DATA.
- FILTER:
  - If the primed flag is 0 (first sample after reset): filt = sample, set primed.
  - Otherwise: filt = filt + ((sample - filt) >>> ALPHA_SHIFT).
  - Use a 17-bit signed difference with an arithmetic shift (rounds toward negative infinity). The result is truncated to 16 bits and always stays within [CCT_MIN, CCT_MAX].
- COMPARE:
  - A sample is out of band when |filt - cct_out| >= HYST. Out of band increments the settle counter, saturating at SETTLE_CNT; in band clears it.
  - Commit when this is the first sample after reset, or when the settle counter reaches SETTLE_CNT.
  - On commit: cct_out <= filt, cct_out_valid <= 1, settle counter cleared, go to OUTPUT.
  - No commit: go to IDLE.
- OUTPUT:
  - cct_out and cct_out_valid are held stable until cct_out_ready=1 is sampled. On that edge cct_out_valid <= 0 and go to IDLE.
  - No polling occurs while in OUTPUT.
- enable=0 only blocks REQ. An in-flight read, filtering or output handshake completes normally.

## Timing
- Reset values:
  - Outputs: read_req=0, cct_out=CCT_DEFAULT, cct_out_valid=0, timeout_pulse=0.
  - Internal: state=IDLE, poll timer=0, primed=0, settle counter=0, filt=CCT_DEFAULT.
- rst asserted in any state, including mid-handshake, forces the reset values on the next edge. A pending cct_out_valid is dropped.
- Latency: cct_in_valid is sampled high at edge N. cct_out and cct_out_valid update at edge N+2 and are visible in cycle N+3.
- If cct_out_ready is already high when cct_out_valid rises, the transfer completes one cycle later. The minimum valid pulse is 1 cycle.
- First read_req fires POLL_CYCLES+1 cycles after reset release when enable=1 and als_busy=0.
- timeout_pulse and read_req are never high in the same cycle.

## Test plan
- First sample: after reset, cct_in=7000 is returned. Required: read_req pulses once, cct_out=7000 with cct_out_valid 3 cycles after the strobe, and cct_out holds while cct_out_ready=0 for 10 cycles.
- Clamp: cct_in=9000 on the first sample gives cct_out=8000. cct_in=1000 on the first sample gives cct_out=3000.
- EMA: committed value and filt both 6000, then three samples of 7000. Required: filt goes 6250, 6437, 6577. The commit occurs on the third sample with cct_out=6577. There is no output on samples 1 and 2.
- Hysteresis: committed value 6000, repeated samples of 6080. Required: filt stays within 100 K and no cct_out_valid is raised over 10 polls.
- Timeout: read_req is issued and no cct_in_valid arrives. Required: timeout_pulse fires TIMEOUT_CYCLES cycles later, the next read_req follows POLL_CYCLES+1 cycles after that, and cct_out is unchanged.
- Gating and reset:
  - With als_busy=1, the FSM holds in REQ with no read_req.
  - With enable=0, no read_req is issued.
  - rst is asserted while in OUTPUT with valid high. Required: valid drops next cycle and cct_out=6500.
